// File: rtl/hamming_dist_pipe_pkg.sv
// Shared definitions for the census-cost datapath: mode encodings and the
// constant ceil-log2 helper used to size adder trees and count outputs.
package hamming_dist_pipe_pkg;

   localparam logic MODE_POP = 1'b0;
   localparam logic MODE_HAM = 1'b1;

   function automatic int CLOG2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/hamming_dist_pipe_pc_tree_level.sv
// One combinational level of the population-count adder tree. Adjacent sums
// are added pairwise into sums one bit wider. An odd trailing sum is passed
// through zero-extended.
module hamming_dist_pipe_pc_tree_level #(
   parameter int IN_W = 1,
   parameter int N_IN = 2
) (
   input  logic [N_IN*IN_W-1:0]             in_sums,
   output logic [((N_IN+1)/2)*(IN_W+1)-1:0] out_sums
);

   localparam int N_OUT = (N_IN + 1) / 2;
   localparam int OUT_W = IN_W + 1;

   for (genvar i = 0; i < N_OUT; i++) begin : g_pair
      if (2 * i + 1 < N_IN) begin : g_add
         assign out_sums[i*OUT_W +: OUT_W] = {1'b0, in_sums[2*i*IN_W +: IN_W]}
                                           + {1'b0, in_sums[(2*i+1)*IN_W +: IN_W]};
      end else begin : g_pass
         assign out_sums[i*OUT_W +: OUT_W] = {1'b0, in_sums[2*i*IN_W +: IN_W]};
      end
   end

endmodule

// File: rtl/hamming_dist_pipe.sv
// Pipelined, back-pressurable popcount / census Hamming distance.
// Stage 0 registers the mode-selected vector (zero-padded to a power of two).
// The adder tree levels that follow are cut evenly by the remaining registers.
// Every stage has a valid bit. A stage advances when it is empty or when
// the stage after it advances, so bubbles collapse.
module hamming_dist_pipe
   import hamming_dist_pipe_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 3,
   parameter int TAG_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      mode,
   input  logic [WIDTH-1:0]          in_a,
   input  logic [WIDTH-1:0]          in_b,
   input  logic [TAG_W-1:0]          in_tag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CLOG2(WIDTH+1)-1:0] out_count,
   output logic [TAG_W-1:0]          out_tag
);

   localparam int OUT_W     = CLOG2(WIDTH + 1);
   localparam int LEVELS    = CLOG2(WIDTH);
   localparam int PW        = 1 << LEVELS;
   localparam int PER       = (STAGES > 1) ? (LEVELS + STAGES - 2) / (STAGES - 1) : LEVELS;
   localparam int FINAL_STG = (STAGES > 1) ? (LEVELS + PER - 1) / PER : 0;

   logic [STAGES:0]   adv;
   logic [STAGES-1:0] vld;
   logic [TAG_W-1:0]  tag_q [STAGES];
   logic [PW-1:0]     v_next;
   logic [PW-1:0]     v_q;

   assign v_next = PW'((mode == MODE_POP) ? in_a : (in_a ^ in_b));

   // Advance chain from the output back to the input; an empty stage always advances
   always_comb begin
      adv = '0;
      adv[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         adv[i] = !vld[i] || adv[i + 1];
      end
   end

   // Valid bits and tags move together; a stage loads its upstream neighbour when it advances
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld <= '0;
         for (int i = 0; i < STAGES; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         if (adv[0]) begin
            vld[0]   <= in_valid;
            tag_q[0] <= in_tag;
         end
         for (int i = 1; i < STAGES; i++) begin
            if (adv[i]) begin
               vld[i]   <= vld[i - 1];
               tag_q[i] <= tag_q[i - 1];
            end
         end
      end
   end

   // Stage 0 holds the selected census vector; reset so a 1-stage pipe reads zero in reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q <= '0;
      end else if (adv[0]) begin
         v_q <= v_next;
      end
   end

   // Adder tree: level k carries PW>>k sums of k+1 bits, registered at each cut point
   for (genvar k = 0; k <= LEVELS; k++) begin : lvl
      localparam int LW = k + 1;
      localparam int LN = PW >> k;
      logic [LN*LW-1:0] sum_o;
      if (k == 0) begin : g_leaf
         assign sum_o = v_q;
      end else begin : g_node
         localparam bit IS_REG = (STAGES > 1) && (((k % PER) == 0) || (k == LEVELS));
         localparam int STG    = (k + PER - 1) / PER;
         logic [LN*LW-1:0] sum_c;
         hamming_dist_pipe_pc_tree_level #(
            .IN_W (k),
            .N_IN (PW >> (k - 1))
         ) u_level (
            .in_sums  (lvl[k-1].sum_o),
            .out_sums (sum_c)
         );
         if (IS_REG) begin : g_reg
            // Cut register for this level, moving with its stage's advance
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  sum_o <= '0;
               end else if (adv[STG]) begin
                  sum_o <= sum_c;
               end
            end
         end else begin : g_comb
            assign sum_o = sum_c;
         end
      end
   end

   // Stages past the one that completes the tree just carry the final sum forward
   for (genvar j = FINAL_STG; j < STAGES; j++) begin : tl
      logic [LEVELS:0] q;
      if (j == FINAL_STG) begin : g_head
         assign q = lvl[LEVELS].sum_o;
      end else begin : g_hold
         // Pass-through register for the finished count
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               q <= '0;
            end else if (adv[j]) begin
               q <= tl[j-1].q;
            end
         end
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = vld[STAGES-1];
   assign out_tag   = tag_q[STAGES-1];
   assign out_count = OUT_W'(tl[STAGES-1].q);

endmodule

// File: tb/tb_hamming_dist_pipe.sv
// Bench for hamming_dist_pipe: a 32-bit/3-stage instance and a 25-bit/1-stage instance.
// Results are checked against a bit-counting reference model and an in-order scoreboard.
module tb_hamming_dist_pipe;
   import hamming_dist_pipe_pkg::*;

   localparam int WIDTH   = 32;
   localparam int STAGES  = 3;
   localparam int TAG_W   = 8;
   localparam int OUT_W   = 6;
   localparam int WIDTH2  = 25;
   localparam int STAGES2 = 1;
   localparam int OUT_W2  = 5;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid, in_ready, mode, out_valid, out_ready;
   logic [WIDTH-1:0]   in_a, in_b;
   logic [TAG_W-1:0]   in_tag, out_tag;
   logic [OUT_W-1:0]   out_count;

   logic               in_valid2, in_ready2, mode2, out_valid2, out_ready2;
   logic [WIDTH2-1:0]  in_a2, in_b2;
   logic [TAG_W-1:0]   in_tag2, out_tag2;
   logic [OUT_W2-1:0]  out_count2;

   typedef struct {
      int               count;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t sb[$];
   int   check_count = 0;
   int   pass_count  = 0;

   always #5 clk = ~clk;

   hamming_dist_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_count(out_count), .out_tag(out_tag)
   );

   hamming_dist_pipe #(.WIDTH(WIDTH2), .STAGES(STAGES2), .TAG_W(TAG_W)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .mode(mode2),
      .in_a(in_a2), .in_b(in_b2), .in_tag(in_tag2), .out_valid(out_valid2),
      .out_ready(out_ready2), .out_count(out_count2), .out_tag(out_tag2)
   );

   function automatic int ref_count(input logic m, input logic [31:0] a,
                                    input logic [31:0] b, input int w);
      int          n;
      logic [31:0] v;
      n = 0;
      v = (m == MODE_HAM) ? (a ^ b) : a;
      for (int i = 0; i < w; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      #12;
      check_count++;
      if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid);
      else pass_count++;
      check_count++;
      if (out_count !== '0) $display("[TB] FAIL reset_out_count: got %0d, expected 0", out_count);
      else pass_count++;
      check_count++;
      if (out_tag !== '0) $display("[TB] FAIL reset_out_tag: got %0d, expected 0", out_tag);
      else pass_count++;
      check_count++;
      if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
      else pass_count++;
      check_count++;
      if (out_valid2 !== 1'b0 || out_count2 !== '0)
         $display("[TB] FAIL reset_dut2: got valid %b count %0d, expected 0/0", out_valid2, out_count2);
      else pass_count++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_all_ones();
      int lat;
      @(negedge clk);
      in_valid = 1'b1; mode = MODE_POP; in_a = 32'hFFFF_FFFF; in_b = $urandom;
      in_tag = 8'hA5; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_count++;
      if (lat !== STAGES - 1) $display("[TB] FAIL all_ones_latency: got %0d edges, expected %0d", lat, STAGES - 1);
      else pass_count++;
      check_count++;
      if (out_count !== 6'd32) $display("[TB] FAIL all_ones_count: got %0d, expected 32", out_count);
      else pass_count++;
      check_count++;
      if (out_tag !== 8'hA5) $display("[TB] FAIL all_ones_tag: got %h, expected a5", out_tag);
      else pass_count++;
      repeat (STAGES + 2) @(negedge clk);
   endtask

   task automatic test_hamming();
      logic [31:0] va [2];
      logic [31:0] vb [2];
      int          ve [2];
      int          lat;
      va[0] = 32'hF0F0_F0F0; vb[0] = 32'h0F0F_F0F0; ve[0] = 16;
      va[1] = 32'h1234_5678; vb[1] = 32'h1234_5678; ve[1] = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         in_valid = 1'b1; mode = MODE_HAM; in_a = va[i]; in_b = vb[i];
         in_tag = TAG_W'(16 + i); out_ready = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         lat = 0;
         while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check_count++;
         if (out_count !== OUT_W'(ve[i]) || out_tag !== TAG_W'(16 + i))
            $display("[TB] FAIL hamming_%0d: got count %0d tag %0d, expected count %0d tag %0d",
                     i, out_count, out_tag, ve[i], 16 + i);
         else pass_count++;
         repeat (STAGES + 2) @(negedge clk);
      end
   endtask

   task automatic test_stream(input string name, input int n, input int rdy_pct, input int vld_pct);
      int   sent, got, cyc, first, last;
      exp_t e;
      sent = 0; got = 0; cyc = 0; first = -1; last = -1;
      sb.delete();
      while ((sent < n || got < n) && cyc < 5000) begin
         @(negedge clk);
         if (sent < n && $urandom_range(99) < vld_pct) begin
            in_valid = 1'b1; mode = 1'($urandom_range(1));
            in_a = $urandom; in_b = $urandom; in_tag = TAG_W'(sent);
         end else begin
            in_valid = 1'b0;
         end
         out_ready = ($urandom_range(99) < rdy_pct);
         #1;
         if (out_valid && out_ready) begin
            check_count++;
            if (sb.size() == 0) begin
               $display("[TB] FAIL %s_extra: got tag %0d, expected no result", name, out_tag);
            end else begin
               e = sb.pop_front();
               if (out_count !== OUT_W'(e.count) || out_tag !== e.tag)
                  $display("[TB] FAIL %s_result: got count %0d tag %0d, expected count %0d tag %0d",
                           name, out_count, out_tag, e.count, e.tag);
               else pass_count++;
            end
            if (first < 0) first = cyc;
            last = cyc;
            got++;
         end
         if (in_valid && in_ready) begin
            e.count = ref_count(mode, in_a, in_b, WIDTH);
            e.tag   = in_tag;
            sb.push_back(e);
            sent++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      check_count++;
      if (got != n || sent != n)
         $display("[TB] FAIL %s_complete: got %0d sent %0d received, expected %0d each", name, sent, got, n);
      else pass_count++;
      if (rdy_pct >= 100 && vld_pct >= 100) begin
         check_count++;
         if (last - first != n - 1)
            $display("[TB] FAIL %s_throughput: got %0d cycles span, expected %0d", name, last - first, n - 1);
         else pass_count++;
      end
      out_ready = 1'b1;
      repeat (STAGES + 2) @(negedge clk);
   endtask

   task automatic test_stall();
      int               acc, got, unstable, cyc;
      bit               have;
      logic [OUT_W-1:0] held_count;
      logic [TAG_W-1:0] held_tag;
      exp_t             e;
      acc = 0; got = 0; unstable = 0; have = 1'b0;
      held_count = '0; held_tag = '0;
      sb.delete();
      for (int c = 0; c < STAGES + 4; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         in_valid = 1'b1; mode = MODE_HAM; in_a = $urandom; in_b = $urandom;
         in_tag = TAG_W'(100 + acc);
         #1;
         if (out_valid) begin
            if (!have) begin
               held_count = out_count; held_tag = out_tag; have = 1'b1;
            end else if (out_count !== held_count || out_tag !== held_tag) begin
               unstable++;
            end
         end
         if (in_valid && in_ready) begin
            e.count = ref_count(mode, in_a, in_b, WIDTH);
            e.tag   = in_tag;
            sb.push_back(e);
            acc++;
         end
      end
      check_count++;
      if (acc != STAGES) $display("[TB] FAIL stall_accepts: got %0d, expected %0d", acc, STAGES);
      else pass_count++;
      check_count++;
      if (in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready: got %b, expected 0", in_ready);
      else pass_count++;
      check_count++;
      if (!have || unstable != 0)
         $display("[TB] FAIL stall_hold: got valid_seen %0d changes %0d, expected 1 and 0", have, unstable);
      else pass_count++;
      cyc = 0;
      while (got < STAGES && cyc < 20) begin
         @(negedge clk);
         in_valid = 1'b0; out_ready = 1'b1;
         #1;
         if (out_valid) begin
            check_count++;
            if (sb.size() == 0) begin
               $display("[TB] FAIL stall_drain_extra: got tag %0d, expected no result", out_tag);
            end else begin
               e = sb.pop_front();
               if (out_count !== OUT_W'(e.count) || out_tag !== e.tag)
                  $display("[TB] FAIL stall_drain: got count %0d tag %0d, expected count %0d tag %0d",
                           out_count, out_tag, e.count, e.tag);
               else pass_count++;
            end
            got++;
         end
         cyc++;
      end
      check_count++;
      if (got != STAGES) $display("[TB] FAIL stall_drain_count: got %0d, expected %0d", got, STAGES);
      else pass_count++;
      repeat (STAGES + 2) @(negedge clk);
   endtask

   task automatic test_midreset();
      int lat;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; mode = MODE_POP; in_a = $urandom | 32'h1; in_tag = TAG_W'(50 + i);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check_count++;
      if (out_valid !== 1'b1) $display("[TB] FAIL midreset_filled: got %b, expected 1", out_valid);
      else pass_count++;
      #2;
      rst = 1'b0;
      #1;
      check_count++;
      if (out_valid !== 1'b0 || out_count !== '0 || out_tag !== '0)
         $display("[TB] FAIL midreset_async: got valid %b count %0d tag %0d, expected 0/0/0",
                  out_valid, out_count, out_tag);
      else pass_count++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; mode = MODE_POP; in_a = 32'h0000_00FF; in_tag = 8'h77; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_count++;
      if (out_tag !== 8'h77 || out_count !== 6'd8)
         $display("[TB] FAIL midreset_first: got tag %h count %0d, expected tag 77 count 8", out_tag, out_count);
      else pass_count++;
      repeat (STAGES + 2) @(negedge clk);
   endtask

   task automatic test_w25();
      logic [WIDTH2-1:0] a, b;
      logic              m;
      int                exp_n;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) begin
            a = '1; b = '0; m = MODE_POP;
         end else if (i == 1) begin
            a = '0; b = '1; m = MODE_POP;
         end else begin
            a = WIDTH2'($urandom); b = WIDTH2'($urandom); m = 1'($urandom_range(1));
         end
         exp_n = ref_count(m, 32'(a), 32'(b), WIDTH2);
         @(negedge clk);
         in_valid2 = 1'b1; mode2 = m; in_a2 = a; in_b2 = b;
         in_tag2 = TAG_W'(200 + i); out_ready2 = 1'b1;
         @(posedge clk);
         #1;
         in_valid2 = 1'b0;
         check_count++;
         if (out_valid2 !== 1'b1 || out_count2 !== OUT_W2'(exp_n) || out_tag2 !== TAG_W'(200 + i))
            $display("[TB] FAIL w25_beat_%0d: got valid %b count %0d tag %0d, expected 1 count %0d tag %0d",
                     i, out_valid2, out_count2, out_tag2, exp_n, 200 + i);
         else pass_count++;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got no end of test, expected finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b0;
      in_valid = 1'b0; mode = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
      in_valid2 = 1'b0; mode2 = 1'b0; in_a2 = '0; in_b2 = '0; in_tag2 = '0; out_ready2 = 1'b1;
      test_reset();
      test_all_ones();
      test_hamming();
      test_stream("stream", 100, 100, 100);
      test_stall();
      test_stream("backpressure", 200, 50, 60);
      test_midreset();
      test_w25();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
